measurement_shot_sequencer: RTL and testbench



---
 rtl/meas_seq_pkg.sv | 23 ++
 rtl/meas_lfsr32.sv | 26 ++
 rtl/measurement_shot_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_measurement_shot_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_seq_pkg.sv
// Shared types, widths and the LFSR step rule for the measurement shot sequencer.
package meas_seq_pkg;

  localparam int unsigned DEF_AMP_W = 16;
  localparam int unsigned PROB_W    = 2 * DEF_AMP_W + 1;
  localparam int unsigned CUM_W     = 2 * DEF_AMP_W + 3;
  localparam int unsigned RND_W     = 32;

  localparam logic [RND_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    PROB,
    SHOT,
    FIN
  } state_e;

  // One right-shifting Galois step; taps fold in when the bit shifted out is 1.
  function automatic logic [RND_W-1:0] lfsr_step(input logic [RND_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/meas_lfsr32.sv
// 32-bit Galois LFSR with step enable; reset reloads the seed.
module meas_lfsr32
  import meas_seq_pkg::*;
#(
  parameter logic [RND_W-1:0] SEED = 32'hACE1_1D5B
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_step,
  output logic [RND_W-1:0] o_state
);

  logic [RND_W-1:0] r_state;

  // Hold unless stepped; seed restored only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/measurement_shot_sequencer.sv
// Runs N measurement shots on a 2-qubit state vector and accumulates an outcome histogram.
// PROB builds the cumulative distribution through one shared squarer/adder; SHOT issues one
// scaled random draw per cycle and bins it on the following cycle.
module measurement_shot_sequencer
  import meas_seq_pkg::*;
#(
  parameter int unsigned AMP_W     = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned SHOT_W    = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1D5B
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SHOT_W-1:0]       num_shots,
  input  logic signed [AMP_W-1:0] amp00_real,
  input  logic signed [AMP_W-1:0] amp00_imag,
  input  logic signed [AMP_W-1:0] amp01_real,
  input  logic signed [AMP_W-1:0] amp01_imag,
  input  logic signed [AMP_W-1:0] amp10_real,
  input  logic signed [AMP_W-1:0] amp10_imag,
  input  logic signed [AMP_W-1:0] amp11_real,
  input  logic signed [AMP_W-1:0] amp11_imag,
  output logic                    busy,
  output logic                    done,
  output logic                    err_zero_norm,
  output logic [CNT_W-1:0]        result0,
  output logic [CNT_W-1:0]        result1,
  output logic [CNT_W-1:0]        result2,
  output logic [CNT_W-1:0]        result3
);

  localparam int unsigned P_W = 2 * AMP_W + 1;
  localparam int unsigned C_W = 2 * AMP_W + 3;
  localparam int unsigned M_W = RND_W + C_W;

  state_e                  r_state, w_state_next;
  logic [1:0]              r_idx;
  logic [SHOT_W-1:0]       r_remain;
  logic signed [AMP_W-1:0] r_amp_re [4];
  logic signed [AMP_W-1:0] r_amp_im [4];
  logic [C_W-1:0]          r_cum [4];
  logic [C_W-1:0]          r_rnd;
  logic                    r_rnd_vld;
  logic [CNT_W-1:0]        r_res [4];
  logic                    r_busy, r_done, r_err;

  logic                    w_issue;
  logic [RND_W-1:0]        w_lfsr, w_lfsr_next;
  logic signed [AMP_W-1:0] w_re, w_im;
  logic signed [2*AMP_W-1:0] w_sq_re, w_sq_im;
  logic [P_W-1:0]          w_prob;
  logic [C_W-1:0]          w_cum_prev, w_cum_new;
  logic [C_W-1:0]          w_rnd;
  logic [1:0]              w_outcome;

  meas_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_step  (w_issue),
    .o_state (w_lfsr)
  );

  // Draw uses the freshly stepped LFSR value; r = (lfsr * c3) >> 32 is always below c3.
  assign w_lfsr_next = lfsr_step(w_lfsr);
  assign w_rnd       = C_W'((M_W'(w_lfsr_next) * M_W'(r_cum[3])) >> RND_W);

  // Shared squarer/adder: squares are non-negative so zero-extension is exact.
  assign w_re       = r_amp_re[r_idx];
  assign w_im       = r_amp_im[r_idx];
  assign w_sq_re    = w_re * w_re;
  assign w_sq_im    = w_im * w_im;
  assign w_prob     = {1'b0, w_sq_re} + {1'b0, w_sq_im};
  assign w_cum_prev = (r_idx == 2'd0) ? '0 : r_cum[r_idx - 2'd1];
  assign w_cum_new  = w_cum_prev + {2'b00, w_prob};

  // Compare stage: smallest k with r < c_k; r < c3 always, so 3 is the fallback.
  always_comb begin
    w_outcome = 2'd3;
    if (r_rnd < r_cum[2]) w_outcome = 2'd2;
    if (r_rnd < r_cum[1]) w_outcome = 2'd1;
    if (r_rnd < r_cum[0]) w_outcome = 2'd0;
  end

  // Next-state logic and shot-issue strobe.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_next = PROB;
      PROB: begin
        if (r_idx == 2'd3) begin
          w_state_next = ((w_cum_new == '0) || (r_remain == '0)) ? FIN : SHOT;
        end
      end
      SHOT: begin
        w_issue = 1'b1;
        if (r_remain == SHOT_W'(1)) w_state_next = FIN;
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture, cumulative build, shot pipeline, histogram and handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_remain  <= '0;
      r_rnd     <= '0;
      r_rnd_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_amp_re[k] <= '0;
        r_amp_im[k] <= '0;
        r_cum[k]    <= '0;
        r_res[k]    <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_rnd_vld <= w_issue;
      if (w_issue) begin
        r_rnd    <= w_rnd;
        r_remain <= r_remain - SHOT_W'(1);
      end
      if (r_rnd_vld && (r_res[w_outcome] != '1)) begin
        r_res[w_outcome] <= r_res[w_outcome] + CNT_W'(1);
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_amp_re[0] <= amp00_real;
            r_amp_im[0] <= amp00_imag;
            r_amp_re[1] <= amp01_real;
            r_amp_im[1] <= amp01_imag;
            r_amp_re[2] <= amp10_real;
            r_amp_im[2] <= amp10_imag;
            r_amp_re[3] <= amp11_real;
            r_amp_im[3] <= amp11_imag;
            r_remain    <= num_shots;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            for (int k = 0; k < 4; k++) r_res[k] <= '0;
          end
        end
        PROB: begin
          r_cum[r_idx] <= w_cum_new;
          r_idx        <= r_idx + 2'd1;
        end
        FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_err  <= (r_cum[3] == '0);
        end
        default: ;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err_zero_norm = r_err;
  assign result0       = r_res[0];
  assign result1       = r_res[1];
  assign result2       = r_res[2];
  assign result3       = r_res[3];

endmodule

// File: tb/tb_measurement_shot_sequencer.sv
// Self-checking bench for measurement_shot_sequencer against a shot-by-shot reference model.
module tb_measurement_shot_sequencer;

  localparam logic [31:0] SEED = 32'hACE1_1D5B;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] num_shots;
  logic [15:0] a00r, a00i, a01r, a01i, a10r, a10i, a11r, a11i;
  logic        busy, done, err_zero_norm;
  logic [7:0]  result0, result1, result2, result3;
  logic [7:0]  res [4];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_lfsr;
  int          exp_res [4];
  logic        exp_err;
  int          exp_edge;

  always #5 clk = ~clk;

  always_comb begin
    res[0] = result0;
    res[1] = result1;
    res[2] = result2;
    res[3] = result3;
  end

  measurement_shot_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_shots     (num_shots),
    .amp00_real    (a00r),
    .amp00_imag    (a00i),
    .amp01_real    (a01r),
    .amp01_imag    (a01i),
    .amp10_real    (a10r),
    .amp10_imag    (a10i),
    .amp11_real    (a11r),
    .amp11_imag    (a11i),
    .busy          (busy),
    .done          (done),
    .err_zero_norm (err_zero_norm),
    .result0       (result0),
    .result1       (result1),
    .result2       (result2),
    .result3       (result3)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Reference: probabilities, CDF, then each shot drawn and binned with saturation.
  task automatic model_run(input logic [7:0][15:0] amps, input int n);
    longint c [4];
    longint acc;
    longint re, im, r;
    logic [66:0] prod;
    int k;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      re  = longint'($signed(amps[2*i]));
      im  = longint'($signed(amps[2*i+1]));
      acc = acc + re * re + im * im;
      c[i] = acc;
    end
    exp_res  = '{0, 0, 0, 0};
    exp_err  = (acc == 0);
    exp_edge = (acc == 0 || n == 0) ? 5 : 5 + n;
    if (acc != 0) begin
      for (int s = 0; s < n; s++) begin
        m_lfsr = lfsr_next(m_lfsr);
        prod   = 67'(m_lfsr) * 67'(acc);
        r      = longint'(prod >> 32);
        k      = 0;
        while (k < 3 && r >= c[k]) k++;
        if (exp_res[k] < 255) exp_res[k]++;
      end
    end
  endtask

  task automatic set_amps(input logic [7:0][15:0] a);
    a00r = a[0]; a00i = a[1]; a01r = a[2]; a01i = a[3];
    a10r = a[4]; a10i = a[5]; a11r = a[6]; a11i = a[7];
  endtask

  function automatic logic [7:0][15:0] rand_amps();
    logic [7:0][15:0] a;
    for (int i = 0; i < 8; i++) a[i] = 16'($urandom);
    return a;
  endfunction

  // Full run: start at E0, scramble inputs afterwards, optional ignored start pulse at
  // edge restart_at, then check done timing, busy, err and the histogram.
  task automatic do_run(input string name, input logic [7:0][15:0] amps, input int n,
                        input int restart_at);
    int got_edge;
    bit busy_ok;
    got_edge = -1;
    busy_ok  = 1'b1;
    model_run(amps, n);
    set_amps(amps);
    num_shots = 16'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_amps(rand_amps());
    num_shots = 16'($urandom);
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int e = 1; e <= exp_edge + 5; e++) begin
      start = (e == restart_at);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        got_edge = e;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    n_tests++;
    if (got_edge != exp_edge) begin
      n_fail++;
      $display("FAIL %s done_edge: got %0d expected %0d", name, got_edge, exp_edge);
    end
    n_tests++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL %s busy_during_run: got low expected high", name);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    n_tests++;
    if (err_zero_norm !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_zero_norm: got %b expected %b", name, err_zero_norm, exp_err);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (res[k] !== 8'(exp_res[k])) begin
        n_fail++;
        $display("FAIL %s result%0d: got %0d expected %0d", name, k, res[k], exp_res[k]);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse_width: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_lfsr = SEED;
    n_tests++;
    if ({busy, done, err_zero_norm} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b%b%b expected 000", busy, done, err_zero_norm);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (res[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_result%0d: got %0d expected 0", k, res[k]);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_start: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single_outcome();
    logic [7:0][15:0] a;
    a = '0;
    a[0] = 16'd128;
    do_run("single_outcome", a, 200, -1);
    n_tests++;
    if (result0 !== 8'd200) begin
      n_fail++;
      $display("FAIL single_outcome_const: result0 got %0d expected 200", result0);
    end
  endtask

  task automatic test_saturation();
    logic [7:0][15:0] a;
    a = '0;
    a[7] = -16'sd90;
    do_run("saturation", a, 300, -1);
    n_tests++;
    if (result3 !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation_const: result3 got %0d expected 255", result3);
    end
  endtask

  task automatic test_zero_norm();
    logic [7:0][15:0] a;
    a = '0;
    do_run("zero_norm", a, 50, -1);
    a[2] = 16'd10;
    do_run("after_zero_norm", a, 1, -1);
  endtask

  task automatic test_distribution();
    logic [7:0][15:0] a;
    int sum;
    a = '0;
    for (int i = 0; i < 4; i++) a[2*i] = 16'd64;
    do_run("uniform", a, 255, -1);
    sum = int'(result0) + int'(result1) + int'(result2) + int'(result3);
    n_tests++;
    if (sum != 255) begin
      n_fail++;
      $display("FAIL uniform_sum: got %0d expected 255", sum);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (res[k] < 8'd35 || res[k] > 8'd95) begin
        n_fail++;
        $display("FAIL uniform_range%0d: got %0d expected 35..95", k, res[k]);
      end
    end
    a = '0;
    a[0] = 16'd128;
    a[2] = 16'd127;
    do_run("two_way", a, 255, -1);
    n_tests++;
    if (result2 !== 8'd0 || result3 !== 8'd0 || result0 < 8'd95 || result0 > 8'd160 ||
        result1 < 8'd95 || result1 > 8'd160) begin
      n_fail++;
      $display("FAIL two_way_range: got %0d %0d %0d %0d expected 95..160 95..160 0 0",
               result0, result1, result2, result3);
    end
  endtask

  task automatic test_restart_ignored();
    do_run("restart_ignored", rand_amps(), 100, 10);
  endtask

  task automatic test_reset_mid_run();
    logic [7:0][15:0] a;
    bit saw_done;
    saw_done = 1'b0;
    a = '0;
    a[0] = 16'd100;
    a[3] = 16'd100;
    set_amps(a);
    num_shots = 16'd100;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      reset = (e == 20);
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_tests++;
    if (busy !== 1'b0 || err_zero_norm !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: busy %b err %b expected 0 0", busy, err_zero_norm);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (res[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL mid_reset_result%0d: got %0d expected 0", k, res[k]);
      end
    end
    reset  = 1'b0;
    m_lfsr = SEED;
    repeat (100) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got activity expected none");
    end
    do_run("after_mid_reset", rand_amps(), 150, -1);
  endtask

  task automatic test_zero_shots();
    logic [7:0][15:0] a;
    a = rand_amps();
    a[0] = 16'd300;
    do_run("zero_shots", a, 0, -1);
    do_run("after_zero_shots", rand_amps(), 120, -1);
  endtask

  task automatic test_random();
    logic [7:0][15:0] a;
    for (int t = 0; t < 8; t++) begin
      a = rand_amps();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          a[2*k]   = '0;
          a[2*k+1] = '0;
        end
      end
      do_run("random", a, int'($urandom_range(0, 300)), -1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_shots = '0;
    set_amps('0);
    m_lfsr    = SEED;
    test_reset();
    test_single_outcome();
    test_saturation();
    test_zero_norm();
    test_distribution();
    test_restart_ignored();
    test_reset_mid_run();
    test_zero_shots();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
